ac_climate_ctrl: RTL and testbench

- Next-generation AC controller combining mode selection, setpoint entry and fan/compressor control in one parametrised block.
- Adds hysteresis on cool/heat demand, a heating path in AUTO, an ECO fan cap, and rate-limited fan ramping.
- Sits between the panel buttons / temperature sensor and the fan driver and compressor/heater relays.

---
 rtl/ac_pkg.sv | 21 ++
 rtl/ac_climate_ctrl_btn_edge.sv | 19 +
 rtl/ac_climate_ctrl.sv | 148 ++++++++++++++
 tb/tb_ac_climate_ctrl.sv | 212 +++++++++++++++++++++
 4 files changed

// File: rtl/ac_pkg.sv
// Shared mode encoding and mode sequencing for the AC climate controller.
// Pure package: no latency, no flow control.
package ac_pkg;

  typedef enum logic [1:0] {
    MODE_OFF  = 2'b00,
    MODE_AUTO = 2'b01,
    MODE_FAST = 2'b10,
    MODE_ECO  = 2'b11
  } mode_t;

  function automatic mode_t next_mode(input mode_t m);
    case (m)
      MODE_OFF:  next_mode = MODE_AUTO;
      MODE_AUTO: next_mode = MODE_FAST;
      MODE_FAST: next_mode = MODE_ECO;
      default:   next_mode = MODE_OFF;
    endcase
  endfunction

endpackage

// File: rtl/ac_climate_ctrl_btn_edge.sv
// Rising-edge detector for an already synchronised button level.
// Edge output is combinational from the live level and one registered copy; no backpressure.
module btn_edge (
  input  logic clk,
  input  logic reset,
  input  logic i_btn,
  output logic o_edge
);

  logic r_prev;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) r_prev <= 1'b0;
    else        r_prev <= i_btn;
  end

  assign o_edge = i_btn & ~r_prev;

endmodule

// File: rtl/ac_climate_ctrl.sv
// AC controller: mode FSM, saturating setpoint, hysteretic cool/heat demand, rate-limited fan ramp.
// All outputs registered (one cycle after the causing input); free-running, no backpressure.
module ac_climate_ctrl
  import ac_pkg::*;
#(
  parameter int TEMP_W   = 7,
  parameter int SET_MIN  = 18,
  parameter int SET_MAX  = 26,
  parameter int SET_RST  = 22,
  parameter int HYST     = 1,
  parameter int FAN_W    = 3,
  parameter int RAMP_DIV = 1000
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              btn_mode,
  input  logic              btn_up,
  input  logic              btn_down,
  input  logic [TEMP_W-1:0] temp_meas,
  input  logic              temp_valid,
  output logic [1:0]        mode,
  output logic [TEMP_W-1:0] setpoint,
  output logic [FAN_W-1:0]  fan_speed,
  output logic              cool_on,
  output logic              heat_on
);

  localparam int FAN_MAX_I = (1 << FAN_W) - 1;
  localparam int ECO_CAP_I = ((FAN_MAX_I >> 1) == 0) ? 1 : (FAN_MAX_I >> 1);
  localparam int CNT_W     = $clog2(RAMP_DIV);

  localparam logic [FAN_W-1:0]  FAN_MAX   = FAN_W'(FAN_MAX_I);
  localparam logic [FAN_W-1:0]  ECO_CAP   = FAN_W'(ECO_CAP_I);
  localparam logic [CNT_W-1:0]  CNT_LAST  = CNT_W'(RAMP_DIV - 1);
  localparam logic [TEMP_W-1:0] SET_MIN_V = TEMP_W'(SET_MIN);
  localparam logic [TEMP_W-1:0] SET_MAX_V = TEMP_W'(SET_MAX);
  localparam logic [TEMP_W-1:0] SET_RST_V = TEMP_W'(SET_RST);

  logic w_mode_edge, w_up_edge, w_down_edge;

  btn_edge u_edge_mode (.clk(clk), .reset(reset), .i_btn(btn_mode), .o_edge(w_mode_edge));
  btn_edge u_edge_up   (.clk(clk), .reset(reset), .i_btn(btn_up),   .o_edge(w_up_edge));
  btn_edge u_edge_down (.clk(clk), .reset(reset), .i_btn(btn_down), .o_edge(w_down_edge));

  mode_t               r_mode;
  logic [TEMP_W-1:0]   r_setpoint;
  logic [TEMP_W-1:0]   r_temp;
  logic [FAN_W-1:0]    r_fan;
  logic                r_cool;
  logic                r_heat;
  logic [CNT_W-1:0]    r_ramp_cnt;

  logic signed [TEMP_W:0] w_err;
  logic signed [TEMP_W:0] w_hyst;
  logic        [TEMP_W:0] w_aerr;
  logic        [TEMP_W:0] w_half;
  logic [FAN_W-1:0]       w_target;
  logic                   w_wrap;

  assign w_err  = $signed({1'b0, r_temp}) - $signed({1'b0, r_setpoint});
  assign w_aerr = w_err[TEMP_W] ? $unsigned(-w_err) : $unsigned(w_err);
  assign w_half = (w_aerr + 1'b1) >> 1;
  assign w_hyst = (r_mode == MODE_ECO) ? $signed((TEMP_W+1)'(2 * HYST))
                                       : $signed((TEMP_W+1)'(HYST));
  assign w_wrap = (r_ramp_cnt == CNT_LAST);

  always_comb begin
    w_target = '0;
    case (r_mode)
      MODE_FAST: w_target = FAN_MAX;
      MODE_AUTO, MODE_ECO: begin
        if (r_cool | r_heat) begin
          w_target = (w_half > (TEMP_W+1)'(FAN_MAX_I)) ? FAN_MAX : w_half[FAN_W-1:0];
          if ((r_mode == MODE_ECO) && (w_target > ECO_CAP)) w_target = ECO_CAP;
        end
      end
      default: w_target = '0;
    endcase
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_mode     <= MODE_OFF;
      r_setpoint <= SET_RST_V;
      r_temp     <= SET_RST_V;
    end else begin
      if (w_mode_edge) r_mode <= next_mode(r_mode);
      // Simultaneous up/down presses cancel; buttons are dead while OFF.
      if ((r_mode != MODE_OFF) && (w_up_edge ^ w_down_edge)) begin
        if (w_up_edge) begin
          if (r_setpoint < SET_MAX_V) r_setpoint <= r_setpoint + 1'b1;
        end else begin
          if (r_setpoint > SET_MIN_V) r_setpoint <= r_setpoint - 1'b1;
        end
      end
      if (temp_valid) r_temp <= temp_meas;
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_cool <= 1'b0;
      r_heat <= 1'b0;
    end else begin
      case (r_mode)
        MODE_FAST: begin
          r_cool <= 1'b1;
          r_heat <= 1'b0;
        end
        MODE_AUTO, MODE_ECO: begin
          if (w_err > w_hyst)                          r_cool <= 1'b1;
          else if (w_err[TEMP_W] || (w_err == '0))     r_cool <= 1'b0;
          if (r_mode == MODE_ECO)                      r_heat <= 1'b0;
          else if (w_err < -w_hyst)                    r_heat <= 1'b1;
          else if (!w_err[TEMP_W])                     r_heat <= 1'b0;
        end
        default: begin
          r_cool <= 1'b0;
          r_heat <= 1'b0;
        end
      endcase
    end
  end

  // A mode change restarts the ramp period and pre-empts a coincident wrap step.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_ramp_cnt <= '0;
      r_fan      <= '0;
    end else begin
      if (w_mode_edge || w_wrap) r_ramp_cnt <= '0;
      else                       r_ramp_cnt <= r_ramp_cnt + 1'b1;
      if (r_mode == MODE_OFF) begin
        r_fan <= '0;
      end else if (w_wrap && !w_mode_edge) begin
        if (r_fan < w_target)      r_fan <= r_fan + 1'b1;
        else if (r_fan > w_target) r_fan <= r_fan - 1'b1;
      end
    end
  end

  assign mode      = r_mode;
  assign setpoint  = r_setpoint;
  assign fan_speed = r_fan;
  assign cool_on   = r_cool;
  assign heat_on   = r_heat;

endmodule

// File: tb/tb_ac_climate_ctrl.sv
// Scoreboard bench: stimulus pushes model predictions per cycle, a monitor pops and compares after each edge.
// Model works on plain integers straight from the behavioural rules.
module tb_ac_climate_ctrl;

  logic       clk = 1'b0;
  logic       reset = 1'b0;
  logic       btn_mode = 1'b0, btn_up = 1'b0, btn_down = 1'b0;
  logic [6:0] temp_meas = 7'd0;
  logic       temp_valid = 1'b0;
  logic [1:0] mode;
  logic [6:0] setpoint;
  logic [2:0] fan_speed;
  logic       cool_on, heat_on;

  ac_climate_ctrl #(.RAMP_DIV(4)) dut (
    .clk(clk), .reset(reset), .btn_mode(btn_mode), .btn_up(btn_up), .btn_down(btn_down),
    .temp_meas(temp_meas), .temp_valid(temp_valid), .mode(mode), .setpoint(setpoint),
    .fan_speed(fan_speed), .cool_on(cool_on), .heat_on(heat_on)
  );

  always #5 clk = ~clk;

  typedef struct {
    int md;
    int sp;
    int fan;
    int cool;
    int heat;
  } exp_t;

  exp_t exp_q[$];
  int   errors = 0;
  int   checks = 0;

  int m_mode, m_set, m_temp, m_fan, m_cnt, m_cool, m_heat;
  int p_m, p_u, p_d;
  int cur_t = 22;

  task automatic chk(input string name, input int act, input int req);
    checks++;
    if (act != req) begin
      errors++;
      $display("FAIL %s: got %0d, expected %0d (t=%0t)", name, act, req, $time);
    end
  endtask

  task automatic model_reset();
    m_mode = 0; m_set = 22; m_temp = 22; m_fan = 0; m_cnt = 0; m_cool = 0; m_heat = 0;
    p_m = 0; p_u = 0; p_d = 0;
  endtask

  task automatic model_step(input int bm, input int bu, input int bd, input int t, input int tv);
    int em, eu, ed, err, aerr, h, tgt, nc, nh, nf, n_mode, n_set;
    exp_t e;
    em = bm & ~p_m;
    eu = bu & ~p_u;
    ed = bd & ~p_d;
    err  = m_temp - m_set;
    aerr = (err < 0) ? -err : err;
    h    = (m_mode == 1) ? 1 : (m_mode == 3) ? 2 : 0;
    nc = 0; nh = 0;
    if (m_mode == 2) nc = 1;
    if (m_mode == 1 || m_mode == 3) begin
      nc = (err > h) ? 1 : (err <= 0) ? 0 : m_cool;
      nh = (m_mode == 3) ? 0 : (err < -h) ? 1 : (err >= 0) ? 0 : m_heat;
    end
    tgt = 0;
    if (m_mode == 2) tgt = 7;
    if ((m_mode == 1 || m_mode == 3) && (m_cool || m_heat)) begin
      tgt = (aerr + 1) / 2;
      if (tgt > 7) tgt = 7;
      if (m_mode == 3 && tgt > 3) tgt = 3;
    end
    nf = m_fan;
    if (m_mode == 0) nf = 0;
    else if (!em && m_cnt == 3) nf = m_fan + ((tgt > m_fan) ? 1 : 0) - ((tgt < m_fan) ? 1 : 0);
    n_set = m_set;
    if (m_mode != 0 && eu != ed) begin
      if (eu && m_set < 26) n_set = m_set + 1;
      if (ed && m_set > 18) n_set = m_set - 1;
    end
    n_mode = em ? (m_mode + 1) % 4 : m_mode;
    m_cnt  = (em || m_cnt == 3) ? 0 : m_cnt + 1;
    if (tv) m_temp = t;
    m_mode = n_mode; m_set = n_set; m_fan = nf; m_cool = nc; m_heat = nh;
    p_m = bm; p_u = bu; p_d = bd;
    e.md = m_mode; e.sp = m_set; e.fan = m_fan; e.cool = m_cool; e.heat = m_heat;
    exp_q.push_back(e);
  endtask

  task automatic cyc(input int bm, input int bu, input int bd, input int tv);
    @(negedge clk);
    reset      = 1'b1;
    btn_mode   = bm[0];
    btn_up     = bu[0];
    btn_down   = bd[0];
    temp_meas  = 7'(cur_t);
    temp_valid = tv[0];
    model_step(bm, bu, bd, cur_t, tv);
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) cyc(0, 0, 0, 0);
  endtask

  task automatic press_mode();
    cyc(1, 0, 0, 0);
    cyc(0, 0, 0, 0);
  endtask

  task automatic set_temp(input int t);
    cur_t = t;
    cyc(0, 0, 0, 1);
  endtask

  task automatic do_reset();
    @(posedge clk);
    #3;
    reset = 1'b0;
    btn_mode = 1'b0; btn_up = 1'b0; btn_down = 1'b0; temp_valid = 1'b0;
    exp_q.delete();
    model_reset();
    #1;
    chk("rst_mode", int'(mode), 0);
    chk("rst_setpoint", int'(setpoint), 22);
    chk("rst_fan", int'(fan_speed), 0);
    chk("rst_cool", int'(cool_on), 0);
    chk("rst_heat", int'(heat_on), 0);
    repeat (2) @(negedge clk);
  endtask

  always @(posedge clk) begin
    #1;
    if (exp_q.size() > 0) begin
      exp_t e;
      e = exp_q.pop_front();
      checks++;
      if (int'(mode) != e.md || int'(setpoint) != e.sp || int'(fan_speed) != e.fan ||
          int'(cool_on) != e.cool || int'(heat_on) != e.heat) begin
        errors++;
        $display("FAIL outputs t=%0t: got mode=%0d sp=%0d fan=%0d cool=%0d heat=%0d, expected mode=%0d sp=%0d fan=%0d cool=%0d heat=%0d",
                 $time, mode, setpoint, fan_speed, cool_on, heat_on, e.md, e.sp, e.fan, e.cool, e.heat);
      end
    end
  end

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation did not finish within the time limit");
    $fatal(1, "watchdog");
  end

  initial begin
    model_reset();
    do_reset();

    for (int i = 0; i < 5; i++) press_mode();
    idle(3);

    do_reset();
    cyc(0, 1, 0, 0); cyc(0, 0, 0, 0);
    press_mode();
    for (int i = 0; i < 6; i++) begin cyc(0, 1, 0, 0); cyc(0, 0, 0, 0); end
    for (int i = 0; i < 10; i++) begin cyc(0, 0, 1, 0); cyc(0, 0, 0, 0); end
    cyc(0, 1, 1, 0); cyc(0, 0, 0, 0);
    idle(2);

    do_reset();
    cur_t = 22;
    press_mode();
    set_temp(23); idle(3);
    set_temp(24); idle(3);
    set_temp(22); idle(3);
    set_temp(20); idle(3);

    set_temp(22); idle(8);
    set_temp(29); idle(24);
    set_temp(22); idle(24);

    press_mode();
    idle(36);
    set_temp(29);
    press_mode();
    idle(24);
    press_mode();
    idle(4);

    do_reset();
    press_mode();
    set_temp(29);
    for (int i = 0; i < 40 && m_fan != 2; i++) cyc(0, 0, 0, 0);
    do_reset();
    idle(3);

    for (int i = 0; i < 3000; i++) begin
      if ($urandom_range(0, 499) == 0) do_reset();
      cur_t = ($urandom_range(0, 19) == 0) ? int'($urandom_range(0, 127))
                                           : int'($urandom_range(12, 34));
      cyc(($urandom_range(0, 15) == 0) ? 1 : 0,
          ($urandom_range(0, 3) == 0) ? 1 : 0,
          ($urandom_range(0, 3) == 0) ? 1 : 0,
          ($urandom_range(0, 3) == 0) ? 1 : 0);
    end

    @(posedge clk);
    #2;
    chk("queue_drained", exp_q.size(), 0);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
